// File: rtl/plot_pkg.sv
// Shared definitions for the text/number plotting blocks.
//   GLYPH_W/GLYPH_H : glyph cell grid (3 columns x 5 rows)
//   GLYPH_BITS      : row-major bitmap width, bit 14-(3*r+c) is cell (r,c)
//   COLOUR_W        : vga_adapter colour width
//   plot_state_e    : renderer FSM encoding
package plot_pkg;
    localparam int GLYPH_W    = 3;
    localparam int GLYPH_H    = 5;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int COLOUR_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_FINISH = 2'd2
    } plot_state_e;
endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational hex digit glyph ROM.
//   digit_i  : 4-bit hex digit
//   bitmap_o : 15-bit row-major 3x5 bitmap, MSB is the top-left cell, 1 = foreground
module hex_glyph_rom
    import plot_pkg::*;
(
    input  logic [3:0]            digit_i,
    output logic [GLYPH_BITS-1:0] bitmap_o
);

    always_comb begin
        bitmap_o = '0;
        case (digit_i)
            4'h0: bitmap_o = 15'b111_101_101_101_111;
            4'h1: bitmap_o = 15'b001_001_001_001_001;
            4'h2: bitmap_o = 15'b111_001_111_100_111;
            4'h3: bitmap_o = 15'b111_001_111_001_111;
            4'h4: bitmap_o = 15'b101_101_111_001_001;
            4'h5: bitmap_o = 15'b111_100_111_001_111;
            4'h6: bitmap_o = 15'b111_100_111_101_111;
            4'h7: bitmap_o = 15'b111_001_001_001_001;
            4'h8: bitmap_o = 15'b111_101_111_101_111;
            4'h9: bitmap_o = 15'b111_101_111_001_001;
            4'hA: bitmap_o = 15'b111_101_111_101_101;
            4'hB: bitmap_o = 15'b100_100_111_101_111;
            4'hC: bitmap_o = 15'b111_100_100_100_111;
            4'hD: bitmap_o = 15'b001_001_111_101_111;
            4'hE: bitmap_o = 15'b111_100_111_100_111;
            4'hF: bitmap_o = 15'b111_100_111_100_100;
            default: bitmap_o = '0;
        endcase
    end

endmodule

// File: rtl/hex_number_plotter.sv
// Sequential hex number renderer feeding the vga_adapter plot port, one pixel per clock.
// Digits are drawn MS first; each glyph cell is expanded to a SCALE x SCALE block.
//   clock, resetn        : clock, synchronous active-low reset
//   start                : request, accepted only while idle (busy=0)
//   value, x0, y0        : number and top-left position, latched on start
//   blank_lz, transp     : leading-zero blanking, transparent background (latched on start)
//   x, y, colour, plot   : registered pixel stream to the adapter
//   busy, done           : render in progress, one-cycle completion pulse
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start; outputs hold last pixel, plot=0
// ST_DRAW   | counters address one pixel per cycle, registered out
// ST_FINISH | last pixel already out; emit done, drop busy
module hex_number_plotter
    import plot_pkg::*;
#(
    parameter int                  NUM_DIGITS = 4,
    parameter int                  SCALE      = 1,
    parameter int                  GAP        = 1,
    parameter int                  X_W        = 8,
    parameter int                  Y_W        = 7,
    parameter logic [COLOUR_W-1:0] FG         = 3'b111,
    parameter logic [COLOUR_W-1:0] BG         = 3'b000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [X_W-1:0]          x0,
    input  logic [Y_W-1:0]          y0,
    input  logic                    blank_lz,
    input  logic                    transp,
    output logic [X_W-1:0]          x,
    output logic [Y_W-1:0]          y,
    output logic [COLOUR_W-1:0]     colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam int D_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int V_W         = 4 * NUM_DIGITS;
    localparam int DIGIT_PITCH = (GLYPH_W + GAP) * SCALE;

    plot_state_e state_q, state_d;

    logic [V_W-1:0]      value_q, value_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic                blank_lz_q, blank_lz_d;
    logic                transp_q, transp_d;

    logic [D_W-1:0]      d_q, d_d;
    logic [2:0]          r_q, r_d;
    logic [1:0]          sr_q, sr_d;
    logic [1:0]          c_q, c_d;
    logic [1:0]          sc_q, sc_d;

    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Leading-zero mask: digit i is blanked when it and every digit above it are zero.
    // Digit 0 is never blanked so a zero value still shows one "0".
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;

    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = blank_lz_q & zero_above & (i != 0);
        end
    end

    logic [3:0]            digit_nib;
    logic [GLYPH_BITS-1:0] glyph_bits;
    logic [3:0]            cell_idx;
    logic                  cell_on;
    logic [X_W-1:0]        x_pix;
    logic [Y_W-1:0]        y_pix;

    assign digit_nib = value_q[4*d_q +: 4];

    hex_glyph_rom u_glyph_rom (
        .digit_i  (digit_nib),
        .bitmap_o (glyph_bits)
    );

    assign cell_idx = 4'(GLYPH_BITS - 1 - (GLYPH_W * int'(r_q) + int'(c_q)));
    assign cell_on  = glyph_bits[cell_idx] & ~lz_mask[d_q];

    // Sums are formed at int width and truncated so coordinates wrap modulo 2^width.
    assign x_pix = X_W'(int'(x0_q) + (NUM_DIGITS - 1 - int'(d_q)) * DIGIT_PITCH
                        + int'(c_q) * SCALE + int'(sc_q));
    assign y_pix = Y_W'(int'(y0_q) + int'(r_q) * SCALE + int'(sr_q));

    logic sc_last, c_last, sr_last, r_last, d_last, pix_last;

    assign sc_last  = (sc_q == 2'(SCALE - 1));
    assign c_last   = (c_q == 2'(GLYPH_W - 1));
    assign sr_last  = (sr_q == 2'(SCALE - 1));
    assign r_last   = (r_q == 3'(GLYPH_H - 1));
    assign d_last   = (d_q == '0);
    assign pix_last = sc_last & c_last & sr_last & r_last & d_last;

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        blank_lz_d = blank_lz_q;
        transp_d   = transp_q;
        d_d        = d_q;
        r_d        = r_q;
        sr_d       = sr_q;
        c_d        = c_q;
        sc_d       = sc_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    value_d    = value;
                    x0_d       = x0;
                    y0_d       = y0;
                    blank_lz_d = blank_lz;
                    transp_d   = transp;
                    d_d        = D_W'(NUM_DIGITS - 1);
                    r_d        = '0;
                    sr_d       = '0;
                    c_d        = '0;
                    sc_d       = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_DRAW;
                end
            end

            ST_DRAW: begin
                x_d      = x_pix;
                y_d      = y_pix;
                colour_d = cell_on ? FG : BG;
                plot_d   = cell_on | ~transp_q;

                // Nested counters, innermost first: sc, c, sr, r, then digit (downwards).
                if (!sc_last) begin
                    sc_d = sc_q + 2'd1;
                end else begin
                    sc_d = '0;
                    if (!c_last) begin
                        c_d = c_q + 2'd1;
                    end else begin
                        c_d = '0;
                        if (!sr_last) begin
                            sr_d = sr_q + 2'd1;
                        end else begin
                            sr_d = '0;
                            if (!r_last) begin
                                r_d = r_q + 3'd1;
                            end else begin
                                r_d = '0;
                                d_d = d_q - D_W'(1);
                            end
                        end
                    end
                end

                if (pix_last) begin
                    d_d     = '0;
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            blank_lz_q <= 1'b0;
            transp_q   <= 1'b0;
            d_q        <= '0;
            r_q        <= '0;
            sr_q       <= '0;
            c_q        <= '0;
            sc_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            blank_lz_q <= blank_lz_d;
            transp_q   <= transp_d;
            d_q        <= d_d;
            r_q        <= r_d;
            sr_q       <= sr_d;
            c_q        <= c_d;
            sc_q       <= sc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
